coherence_bus_arb: RTL

COHERENCE_BUS_ARB -- requirements
Module: coherence_bus_arb

---
 rtl/coherence_bus_arb_if.sv | 35 +++
 rtl/coherence_bus_arb.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_arb_if.sv
// Bus bundle between the cores and the coherence arbiter. The arbiter
// connects through the slave modport; the core side (or a bench) uses master.
interface coherence_bus_arb_if #(
    parameter int NCORE = 4,
    parameter int AW    = 13
);
    localparam int IW = $clog2(NCORE);

    logic [NCORE-1:0]    rd_miss;
    logic [NCORE-1:0]    wr_miss;
    logic [NCORE-1:0]    inv_req;
    logic [NCORE*AW-1:0] req_addr;
    logic [NCORE-1:0]    snoop_hit;
    logic [2*NCORE-1:0]  snoop_state;
    logic                mem_rdy;
    logic [NCORE-1:0]    grant;
    logic [AW-1:0]       bus_addr;
    logic [NCORE-1:0]    snoop_req;
    logic [NCORE-1:0]    snoop_inv;
    logic                fwd_valid;
    logic [IW-1:0]       fwd_src;
    logic                mem_re;
    logic [NCORE-1:0]    done;
    logic                err;

    modport slave (
        input  rd_miss, wr_miss, inv_req, req_addr, snoop_hit, snoop_state, mem_rdy,
        output grant, bus_addr, snoop_req, snoop_inv, fwd_valid, fwd_src, mem_re, done, err
    );

    modport master (
        output rd_miss, wr_miss, inv_req, req_addr, snoop_hit, snoop_state, mem_rdy,
        input  grant, bus_addr, snoop_req, snoop_inv, fwd_valid, fwd_src, mem_re, done, err
    );
endinterface

// File: rtl/coherence_bus_arb.sv
// Snooping coherence bus arbiter: round-robin bus ownership, snoop phase,
// cache-to-cache forwarding or memory read with timeout, then invalidation.
//
// state  | meaning
// IDLE   | arbitrate among requesting cores, latch winner/address/op
// SNOOP  | broadcast search to non-owners, latch hit mask and supplier
// FWD    | two-cycle cache-to-cache transfer from the selected hitter
// MEM_RD | memory read strobe until mem_rdy or timeout
// INV    | one-cycle invalidate of other copies
// DONE   | completion pulse to owner, advance round-robin pointer
module coherence_bus_arb #(
    parameter int NCORE = 4,
    parameter int AW    = 13,
    parameter int TMO   = 15
) (
    input logic                clk,
    input logic                rst_n,
    coherence_bus_arb_if.slave bus
);
    localparam int IW = $clog2(NCORE);

    typedef enum logic [2:0] {IDLE, SNOOP, FWD, MEM_RD, INV, DONE} state_t;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_INV} op_t;

    state_t           state_q, state_d;
    op_t              op_q, arb_op;
    logic [IW-1:0]    winner_q, rr_ptr_q, src_q;
    logic [AW-1:0]    addr_q, arb_addr;
    logic [NCORE-1:0] hit_q;
    logic             fwd_cnt_q;
    logic [7:0]       tmo_cnt_q;
    logic             tmo_q;

    logic [NCORE-1:0] any_req, win_oh, hit_mask;
    logic             arb_found, m_found, s_found;
    logic [IW-1:0]    arb_idx, m_idx, s_idx;

    // Round-robin search from rr_ptr upward, wrapping at NCORE.
    always_comb begin
        logic [IW:0] sum;
        any_req   = bus.rd_miss | bus.wr_miss | bus.inv_req;
        arb_found = 1'b0;
        arb_idx   = '0;
        sum       = '0;
        for (int k = 0; k < NCORE; k++) begin
            sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(NCORE)) sum = sum - (IW+1)'(NCORE);
            if (!arb_found && any_req[sum[IW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = sum[IW-1:0];
            end
        end
    end

    // Winner's address and operation; write miss beats read miss beats invalidate.
    always_comb begin
        arb_addr = '0;
        arb_op   = OP_INV;
        for (int i = 0; i < NCORE; i++) begin
            if (arb_idx == IW'(i)) begin
                arb_addr = bus.req_addr[i*AW +: AW];
                if (bus.wr_miss[i])      arb_op = OP_WR;
                else if (bus.rd_miss[i]) arb_op = OP_RD;
                else                     arb_op = OP_INV;
            end
        end
    end

    // Snoop response: lowest hitter in M is the owner, else lowest hitter in S.
    // Encoding 11 matches neither and therefore behaves as I.
    always_comb begin
        logic [1:0] st;
        st = 2'b00;
        for (int i = 0; i < NCORE; i++) win_oh[i] = (winner_q == IW'(i));
        hit_mask = bus.snoop_hit & ~win_oh;
        m_found  = 1'b0;
        s_found  = 1'b0;
        m_idx    = '0;
        s_idx    = '0;
        for (int i = 0; i < NCORE; i++) begin
            st = bus.snoop_state[2*i +: 2];
            if (hit_mask[i] && st == 2'b10 && !m_found) begin
                m_found = 1'b1;
                m_idx   = IW'(i);
            end
            if (hit_mask[i] && st == 2'b01 && !s_found) begin
                s_found = 1'b1;
                s_idx   = IW'(i);
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (arb_found) state_d = SNOOP;
            SNOOP: begin
                if (op_q == OP_INV)                     state_d = INV;
                else if (op_q == OP_RD && |hit_mask)    state_d = FWD;
                else if (op_q == OP_WR && m_found)      state_d = FWD;
                else                                    state_d = MEM_RD;
            end
            FWD: begin
                if (fwd_cnt_q == 1'b0)
                    state_d = (op_q == OP_WR && |hit_q) ? INV : DONE;
            end
            MEM_RD: begin
                if (bus.mem_rdy)
                    state_d = (op_q == OP_WR && |hit_q) ? INV : DONE;
                else if (tmo_cnt_q == 8'd0)
                    state_d = DONE;
            end
            INV:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus the fields latched along the transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= OP_RD;
            winner_q  <= '0;
            rr_ptr_q  <= '0;
            src_q     <= '0;
            addr_q    <= '0;
            hit_q     <= '0;
            fwd_cnt_q <= 1'b0;
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (arb_found) begin
                        winner_q <= arb_idx;
                        addr_q   <= arb_addr;
                        op_q     <= arb_op;
                        tmo_q    <= 1'b0;
                    end
                end
                SNOOP: begin
                    hit_q     <= hit_mask;
                    src_q     <= m_found ? m_idx : s_idx;
                    fwd_cnt_q <= 1'b1;
                    tmo_cnt_q <= 8'(TMO - 1);
                end
                FWD: fwd_cnt_q <= fwd_cnt_q - 1'b1;
                MEM_RD: begin
                    if (!bus.mem_rdy) begin
                        if (tmo_cnt_q == 8'd0) tmo_q <= 1'b1;
                        else                   tmo_cnt_q <= tmo_cnt_q - 8'd1;
                    end
                end
                DONE: rr_ptr_q <= (winner_q == IW'(NCORE - 1)) ? '0 : winner_q + 1'b1;
                default: ;
            endcase
        end
    end

    // Outputs decoded from the registered state and latched fields only.
    always_comb begin
        bus.grant     = (state_q != IDLE) ? win_oh : '0;
        bus.bus_addr  = (state_q inside {SNOOP, FWD, MEM_RD, INV}) ? addr_q : '0;
        bus.snoop_req = (state_q == SNOOP) ? ~win_oh : '0;
        bus.snoop_inv = '0;
        if (state_q == INV) bus.snoop_inv = (op_q == OP_WR) ? hit_q : ~win_oh;
        bus.fwd_valid = (state_q == FWD);
        bus.fwd_src   = (state_q == FWD) ? src_q : '0;
        bus.mem_re    = (state_q == MEM_RD);
        bus.done      = (state_q == DONE) ? win_oh : '0;
        bus.err       = (state_q == DONE) && tmo_q;
    end
endmodule
